// File: rtl/pokey_clock_ctrl.sv
// POKEY clock/configuration sequencer: AUDCTL/SKCTL registers, 64 kHz / 15 kHz
// base-clock dividers, shared poly counter controls and the STIMER restart strobe.
module pokey_clock_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       wr_en,
    input  logic [3:0] addr,
    input  logic [7:0] data,
    output logic [7:0] audctl,
    output logic [7:0] skctl,
    output logic       poly_enable,
    output logic       poly_init,
    output logic       tick_64k,
    output logic       tick_15k,
    output logic       base_tick,
    output logic       stimer_pulse
);

    localparam logic [3:0] ADDR_AUDCTL = 4'h8;
    localparam logic [3:0] ADDR_STIMER = 4'h9;
    localparam logic [3:0] ADDR_SKCTL  = 4'hF;
    localparam logic [4:0] DIV28_LAST  = 5'd27;
    localparam logic [6:0] DIV114_LAST = 7'd113;

    logic [7:0] audctl_reg;
    logic [7:0] skctl_reg;
    logic       stimer_reg;
    logic [4:0] div28_reg;
    logic [4:0] div28_next;
    logic [6:0] div114_reg;
    logic [6:0] div114_next;

    logic wr_audctl;
    logic wr_stimer;
    logic wr_skctl;
    logic init_active;
    logic enter_init;

    always_comb begin
        wr_audctl   = wr_en && (addr == ADDR_AUDCTL);
        wr_stimer   = wr_en && (addr == ADDR_STIMER);
        wr_skctl    = wr_en && (addr == ADDR_SKCTL);
        init_active = (skctl_reg[1:0] == 2'b00);
        enter_init  = wr_skctl && (data[1:0] == 2'b00);
    end

    // Counters follow the pre-write init state, except that a write entering
    // init clears them at its own edge.
    always_comb begin
        div28_next  = div28_reg;
        div114_next = div114_reg;
        if (init_active || enter_init) begin
            div28_next  = '0;
            div114_next = '0;
        end else if (ce) begin
            div28_next  = (div28_reg == DIV28_LAST)   ? 5'd0 : div28_reg + 5'd1;
            div114_next = (div114_reg == DIV114_LAST) ? 7'd0 : div114_reg + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            audctl_reg <= '0;
            skctl_reg  <= '0;
            stimer_reg <= 1'b0;
            div28_reg  <= '0;
            div114_reg <= '0;
        end else begin
            if (wr_audctl) begin
                audctl_reg <= data;
            end
            if (wr_skctl) begin
                skctl_reg <= data;
            end
            stimer_reg <= wr_stimer;
            div28_reg  <= div28_next;
            div114_reg <= div114_next;
        end
    end

    always_comb begin
        audctl       = audctl_reg;
        skctl        = skctl_reg;
        stimer_pulse = stimer_reg;
        poly_init    = init_active;
        poly_enable  = ce;
        tick_64k     = ce && !init_active && (div28_reg == DIV28_LAST);
        tick_15k     = ce && !init_active && (div114_reg == DIV114_LAST);
        base_tick    = audctl_reg[0] ? tick_15k : tick_64k;
    end

endmodule

// File: tb/tb_pokey_clock_ctrl.sv
// Scoreboard bench for pokey_clock_ctrl: stimulus queues expected tick/strobe
// events, a negedge monitor pops and compares each one the DUT presents.
module tb_pokey_clock_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] addr = 4'h0;
    logic [7:0] data = 8'h00;
    logic [7:0] audctl;
    logic [7:0] skctl;
    logic       poly_enable;
    logic       poly_init;
    logic       tick_64k;
    logic       tick_15k;
    logic       base_tick;
    logic       stimer_pulse;

    pokey_clock_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ce           (ce),
        .wr_en        (wr_en),
        .addr         (addr),
        .data         (data),
        .audctl       (audctl),
        .skctl        (skctl),
        .poly_enable  (poly_enable),
        .poly_init    (poly_init),
        .tick_64k     (tick_64k),
        .tick_15k     (tick_15k),
        .base_tick    (base_tick),
        .stimer_pulse (stimer_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   ce_idx;   // used for tick events
        int   cyc;      // used for strobe events
        logic t64;
        logic t15;
        logic base;
        logic stim;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;   // index of the cycle currently being driven
    int   ce_seq = 0;   // index of the most recent ce=1 cycle

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    task automatic push_tick(input int idx, input logic t64, input logic t15, input logic base);
        exp_t e;
        e.ce_idx = idx; e.cyc = -1; e.t64 = t64; e.t15 = t15; e.base = base; e.stim = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_stim(input int c);
        exp_t e;
        e.ce_idx = -1; e.cyc = c; e.t64 = 1'b0; e.t15 = 1'b0; e.base = 1'b0; e.stim = 1'b1;
        exp_q.push_back(e);
    endtask

    // Drive one clk cycle's inputs just after the rising edge.
    task automatic cycle(input logic ce_v, input logic we, input logic [3:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        ce    = ce_v;
        wr_en = we;
        addr  = a;
        data  = d;
        cyc++;
        if (ce_v) ce_seq++;
    endtask

    always @(negedge clk) begin
        if (tick_64k || tick_15k || base_tick || stimer_pulse) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: t64=%0b t15=%0b base=%0b stim=%0b at cycle %0d ce %0d, none expected",
                         tick_64k, tick_15k, base_tick, stimer_pulse, cyc, ce_seq);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.stim) check("stim_cycle", cyc, e.cyc);
                else        check("tick_ce_index", ce_seq, e.ce_idx);
                check("tick_64k", int'(tick_64k), int'(e.t64));
                check("tick_15k", int'(tick_15k), int'(e.t15));
                check("base_tick", int'(base_tick), int'(e.base));
                check("stimer_pulse", int'(stimer_pulse), int'(e.stim));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base1;
        int base2;
        int w;

        // Reset state.
        #22;
        check("rst_audctl", int'(audctl), 8'h00);
        check("rst_skctl", int'(skctl), 8'h00);
        check("rst_poly_init", int'(poly_init), 1);
        check("rst_stimer", int'(stimer_pulse), 0);
        check("rst_ticks", int'({tick_64k, tick_15k, base_tick}), 0);
        reset_n = 1'b1;

        // Init state: ce every second clk, no ticks expected at all.
        for (int i = 0; i < 1000; i++) begin
            cycle(i % 2 == 0, 1'b0, 4'h0, 8'h00);
            #1;
            check("init_poly_enable", int'(poly_enable), int'(ce));
            check("init_poly_init", int'(poly_init), 1);
        end

        // Run: SKCTL=0x03 then 300 ce; 64k at 28,56,...,280 and 15k at 114,228.
        cycle(1'b0, 1'b1, 4'hF, 8'h03);
        base1 = ce_seq;
        for (int k = 1; k <= 300; k++) begin
            if (k % 28 == 0)  push_tick(base1 + k, 1'b1, 1'b0, 1'b1);
            if (k % 114 == 0) push_tick(base1 + k, 1'b0, 1'b1, 1'b0);
        end
        for (int k = 1; k <= 300; k++) begin
            cycle(1'b1, 1'b0, 4'h0, 8'h00);
            if (k == 1) begin
                #1;
                check("run_poly_init", int'(poly_init), 0);
            end
        end

        // AUDCTL[0]=1 mid-run: phase continues (64k at 308.., 15k at 342, 456).
        cycle(1'b0, 1'b1, 4'h8, 8'h01);
        for (int k = 301; k <= 460; k++) begin
            if (k % 28 == 0)  push_tick(base1 + k, 1'b1, 1'b0, 1'b0);
            if (k % 114 == 0) push_tick(base1 + k, 1'b0, 1'b1, 1'b1);
        end
        for (int k = 301; k <= 460; k++) cycle(1'b1, 1'b0, 4'h0, 8'h00);

        // Back-to-back STIMER writes, plus ignored addresses.
        cycle(1'b0, 1'b1, 4'h9, 8'hAA);
        w = cyc;
        push_stim(w + 1);
        push_stim(w + 2);
        cycle(1'b0, 1'b1, 4'h9, 8'h55);
        cycle(1'b0, 1'b1, 4'h7, 8'hFF);
        cycle(1'b0, 1'b1, 4'hE, 8'h00);
        cycle(1'b0, 1'b0, 4'h0, 8'h00);
        check("stimer_audctl", int'(audctl), 8'h01);
        check("stimer_skctl", int'(skctl), 8'h03);

        // div28 reaches 15 (k=463), enter init with ce on the write edge.
        for (int k = 461; k <= 463; k++) cycle(1'b1, 1'b0, 4'h0, 8'h00);
        cycle(1'b1, 1'b1, 4'hF, 8'h00);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 4'h0, 8'h00);
        #1;
        check("reinit_poly_init", int'(poly_init), 1);

        // Leave init with ce on the write edge; that ce does not count.
        cycle(1'b1, 1'b1, 4'hF, 8'h03);
        base2 = ce_seq;
        push_tick(base2 + 28,  1'b1, 1'b0, 1'b0);
        push_tick(base2 + 56,  1'b1, 1'b0, 1'b0);
        push_tick(base2 + 84,  1'b1, 1'b0, 1'b0);
        push_tick(base2 + 112, 1'b1, 1'b0, 1'b0);
        push_tick(base2 + 114, 1'b0, 1'b1, 1'b1);
        push_tick(base2 + 140, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 139; k++) cycle(1'b1, 1'b0, 4'h0, 8'h00);
        // Enter init on the edge whose ce carries a 64k tick: tick still emitted.
        cycle(1'b1, 1'b1, 4'hF, 8'h00);
        for (int i = 0; i < 200; i++) cycle(1'b1, 1'b0, 4'h0, 8'h00);
        #1;
        check("hold_poly_init", int'(poly_init), 1);

        // Asynchronous reset mid-run while a STIMER strobe is high.
        cycle(1'b0, 1'b1, 4'h8, 8'hFF);
        cycle(1'b0, 1'b1, 4'hF, 8'h03);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'h0, 8'h00);
        cycle(1'b0, 1'b1, 4'h9, 8'h00);
        cycle(1'b0, 1'b0, 4'h0, 8'h00);
        check("pre_rst_stimer", int'(stimer_pulse), 1);
        check("pre_rst_audctl", int'(audctl), 8'hFF);
        check("pre_rst_poly_init", int'(poly_init), 0);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_audctl", int'(audctl), 8'h00);
        check("async_skctl", int'(skctl), 8'h00);
        check("async_poly_init", int'(poly_init), 1);
        check("async_stimer", int'(stimer_pulse), 0);
        cycle(1'b0, 1'b0, 4'h0, 8'h00);
        cycle(1'b0, 1'b0, 4'h0, 8'h00);
        reset_n = 1'b1;
        cycle(1'b1, 1'b0, 4'h0, 8'h00);
        cycle(1'b0, 1'b0, 4'h0, 8'h00);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
